fpu_result_checker: RTL and testbench

Downstream self-check stage for the FPU unit benches (adder, multiplier, divider, float↔int converters). Each cycle it takes one operand/result/golden vector, registers it, compares the DUT result against the golden value, and keeps pass/fail statistics. The first mismatches are kept in a small log FIFO for readout. It replaces the bench's combinational PASS wire and ad-hoc BUSY logic with a handshaked, countable checker.

---
 rtl/fpu_check_pkg.sv | 19 +
 rtl/fpu_result_checker_if.sv | 36 +++
 rtl/fpu_check_log_fifo.sv | 87 ++++++++
 rtl/fpu_result_checker.sv | 168 ++++++++++++++++
 tb/tb_fpu_result_checker.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fpu_check_pkg.sv
// Shared types and F32 helpers for the FPU result checker.
package fpu_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  function automatic logic is_nan_f32(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == 8'hFF) && (v[MANT_MSB:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fpu_result_checker_if.sv
// Vector/handshake bundle between an FPU bench driver and the result checker.
interface fpu_result_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  START;
  logic                  EN;
  logic                  LAST;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [DATA_WIDTH-1:0] O;
  logic [DATA_WIDTH-1:0] GOLDEN;
  logic                  ERR_POP;
  logic                  BUSY;
  logic                  DONE;
  logic [CNT_WIDTH-1:0]  TOTAL_CNT;
  logic [CNT_WIDTH-1:0]  FAIL_CNT;
  logic                  ERR_VALID;
  logic [DATA_WIDTH-1:0] ERR_A;
  logic [DATA_WIDTH-1:0] ERR_B;
  logic [DATA_WIDTH-1:0] ERR_O;
  logic [DATA_WIDTH-1:0] ERR_GOLDEN;
  logic                  LOG_OVF;

  modport master (
    output START, EN, LAST, A, B, O, GOLDEN, ERR_POP,
    input  BUSY, DONE, TOTAL_CNT, FAIL_CNT, ERR_VALID,
           ERR_A, ERR_B, ERR_O, ERR_GOLDEN, LOG_OVF
  );

  modport slave (
    input  START, EN, LAST, A, B, O, GOLDEN, ERR_POP,
    output BUSY, DONE, TOTAL_CNT, FAIL_CNT, ERR_VALID,
           ERR_A, ERR_B, ERR_O, ERR_GOLDEN, LOG_OVF
  );
endinterface

// File: rtl/fpu_check_log_fifo.sv
// Mismatch log: synchronous FIFO with a registered head entry (zero when empty).
module fpu_check_log_fifo #(
  parameter int WIDTH     = 128,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head
);
  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   head_q, head_d;
  logic               head_valid_q, head_valid_d;
  logic               pop_ok, push_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                 (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);

  // Pop is resolved before push, so a full FIFO can accept a push in the same cycle as a pop.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + (LOG_DEPTH+1)'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + (LOG_DEPTH+1)'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
    end
    head_valid_d = (wr_ptr_d != rd_ptr_d);
    head_d       = '0;
    if (!head_valid_d) begin
      head_d = '0;
    end else if (push_ok && (rd_ptr_d[LOG_DEPTH-1:0] == wr_ptr_q[LOG_DEPTH-1:0])) begin
      head_d = push_data;
    end else begin
      head_d = mem_q[rd_ptr_d[LOG_DEPTH-1:0]];
    end
  end

  // Pointer and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  // Storage array; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem_q[wr_ptr_q[LOG_DEPTH-1:0]] <= push_data;
    end
  end

  assign head       = head_q;
  assign head_valid = head_valid_q;

endmodule

// File: rtl/fpu_result_checker.sv
// Self-check stage: registers one FPU vector per cycle, compares result with golden,
// keeps saturating pass/fail counts and logs the first mismatches.
module fpu_result_checker
  import fpu_check_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int NAN_RELAX  = 1,
  parameter int LOG_DEPTH  = 4
) (
  input  logic MCLK,
  input  logic nRST,
  fpu_result_checker_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  start_acc, accept;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [DATA_WIDTH-1:0] s1_o_q, s1_o_d;
  logic [DATA_WIDTH-1:0] s1_g_q, s1_g_d;

  logic [CNT_WIDTH-1:0]  total_q, total_d;
  logic [CNT_WIDTH-1:0]  fail_q, fail_d;
  logic                  ovf_q, ovf_d;

  logic                  match_s, mism_s;
  logic                  log_full_s, log_empty_s, log_valid_s;
  logic [4*DATA_WIDTH-1:0] log_head_s;

  assign start_acc = bus.START && ((state_q == IDLE) || (state_q == DONE));
  assign accept    = bus.EN && (state_q == RUN);

  // Next state; BUSY/DONE are decoded from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_acc) state_d = RUN;
        else           state_d = IDLE;
      end
      RUN: begin
        if (accept && bus.LAST) state_d = DRAIN;
        else                    state_d = RUN;
      end
      DRAIN:   state_d = DONE;
      DONE: begin
        if (start_acc) state_d = RUN;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // FSM state and status outputs.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Stage-1 capture; valid lasts exactly one cycle per accepted vector.
  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_o_d     = s1_o_q;
    s1_g_d     = s1_g_q;
    if (accept) begin
      s1_a_d = bus.A;
      s1_b_d = bus.B;
      s1_o_d = bus.O;
      s1_g_d = bus.GOLDEN;
    end else begin
      s1_a_d = s1_a_q;
    end
  end

  // NaN relaxation treats any two NaN payloads as equal; signed zeros stay distinct.
  always_comb begin
    match_s = (s1_o_q == s1_g_q) ||
              ((NAN_RELAX != 0) && is_nan_f32(s1_o_q[31:0]) && is_nan_f32(s1_g_q[31:0]));
    mism_s  = s1_valid_q && !match_s;
  end

  // Saturating counters and sticky overflow flag, cleared when a run starts.
  always_comb begin
    total_d = total_q;
    fail_d  = fail_q;
    ovf_d   = ovf_q;
    if (start_acc) begin
      total_d = '0;
      fail_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (s1_valid_q && (total_q != CNT_MAX)) total_d = total_q + CNT_WIDTH'(1);
      else                                    total_d = total_q;
      if (mism_s && (fail_q != CNT_MAX)) fail_d = fail_q + CNT_WIDTH'(1);
      else                               fail_d = fail_q;
      if (mism_s && log_full_s && !(bus.ERR_POP && !log_empty_s)) ovf_d = 1'b1;
      else                                                       ovf_d = ovf_q;
    end
  end

  // Stage-1 and statistics registers.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_o_q     <= '0;
      s1_g_q     <= '0;
      total_q    <= '0;
      fail_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_o_q     <= s1_o_d;
      s1_g_q     <= s1_g_d;
      total_q    <= total_d;
      fail_q     <= fail_d;
      ovf_q      <= ovf_d;
    end
  end

  fpu_check_log_fifo #(
    .WIDTH     (4*DATA_WIDTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_log (
    .clk        (MCLK),
    .rst_n      (nRST),
    .clear      (start_acc),
    .push       (mism_s),
    .push_data  ({s1_a_q, s1_b_q, s1_o_q, s1_g_q}),
    .pop        (bus.ERR_POP),
    .full       (log_full_s),
    .empty      (log_empty_s),
    .head_valid (log_valid_s),
    .head       (log_head_s)
  );

  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.TOTAL_CNT  = total_q;
  assign bus.FAIL_CNT   = fail_q;
  assign bus.LOG_OVF    = ovf_q;
  assign bus.ERR_VALID  = log_valid_s;
  assign bus.ERR_A      = log_head_s[4*DATA_WIDTH-1 -: DATA_WIDTH];
  assign bus.ERR_B      = log_head_s[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign bus.ERR_O      = log_head_s[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign bus.ERR_GOLDEN = log_head_s[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench: three checker instances (default, strict NaN, 4-bit counters) share one stimulus.
module tb_fpu_result_checker;
  logic        mclk;
  logic        nrst;
  logic        start, en, last, err_pop;
  logic [31:0] a, b, o, g;
  int          checks;
  int          errors;

  fpu_result_checker_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus0 ();
  fpu_result_checker_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus1 ();
  fpu_result_checker_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  bus2 ();

  assign bus0.START = start;  assign bus1.START = start;  assign bus2.START = start;
  assign bus0.EN = en;        assign bus1.EN = en;        assign bus2.EN = en;
  assign bus0.LAST = last;    assign bus1.LAST = last;    assign bus2.LAST = last;
  assign bus0.A = a;          assign bus1.A = a;          assign bus2.A = a;
  assign bus0.B = b;          assign bus1.B = b;          assign bus2.B = b;
  assign bus0.O = o;          assign bus1.O = o;          assign bus2.O = o;
  assign bus0.GOLDEN = g;     assign bus1.GOLDEN = g;     assign bus2.GOLDEN = g;
  assign bus0.ERR_POP = err_pop; assign bus1.ERR_POP = err_pop; assign bus2.ERR_POP = err_pop;

  fpu_result_checker #(.DATA_WIDTH(32), .CNT_WIDTH(32), .NAN_RELAX(1), .LOG_DEPTH(4))
    dut (.MCLK(mclk), .nRST(nrst), .bus(bus0));
  fpu_result_checker #(.DATA_WIDTH(32), .CNT_WIDTH(32), .NAN_RELAX(0), .LOG_DEPTH(4))
    dut_strict (.MCLK(mclk), .nRST(nrst), .bus(bus1));
  fpu_result_checker #(.DATA_WIDTH(32), .CNT_WIDTH(4), .NAN_RELAX(1), .LOG_DEPTH(4))
    dut_sat (.MCLK(mclk), .nRST(nrst), .bus(bus2));

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic send_vec(input logic [31:0] va, vb, vo, vg, input logic vlast);
    en = 1'b1; a = va; b = vb; o = vo; g = vg; last = vlast;
    step();
    en = 1'b0; last = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    step(); step();
    checks++; if (bus0.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus0.BUSY); end
    checks++; if (bus0.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus0.DONE); end
    checks++; if (bus0.TOTAL_CNT !== 32'd0) begin errors++; $display("FAIL reset_total: got %0d expected 0", bus0.TOTAL_CNT); end
    checks++; if (bus0.ERR_VALID !== 1'b0) begin errors++; $display("FAIL reset_err_valid: got %b expected 0", bus0.ERR_VALID); end
    checks++; if (bus0.ERR_O !== 32'd0) begin errors++; $display("FAIL reset_err_o: got %h expected 0", bus0.ERR_O); end
    checks++; if (bus0.LOG_OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus0.LOG_OVF); end
    nrst = 1'b1;
    step();
  endtask

  task automatic test_en_idle();
    for (int i = 0; i < 3; i++) send_vec(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    step();
    checks++; if (bus0.TOTAL_CNT !== 32'd0) begin errors++; $display("FAIL idle_total: got %0d expected 0", bus0.TOTAL_CNT); end
    checks++; if (bus0.BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus0.BUSY); end
  endtask

  task automatic test_clean_run();
    start_run();
    checks++; if (bus0.BUSY !== 1'b1) begin errors++; $display("FAIL clean_busy_rise: got %b expected 1", bus0.BUSY); end
    for (int i = 0; i < 8; i++) send_vec(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, i == 7);
    checks++; if (bus0.TOTAL_CNT !== 32'd7 || bus0.DONE !== 1'b0) begin errors++;
      $display("FAIL clean_drain: got total %0d done %b expected 7 and 0", bus0.TOTAL_CNT, bus0.DONE); end
    step();
    checks++; if (bus0.DONE !== 1'b1 || bus0.BUSY !== 1'b0) begin errors++;
      $display("FAIL clean_done: got done %b busy %b expected 1 0", bus0.DONE, bus0.BUSY); end
    checks++; if (bus0.TOTAL_CNT !== 32'd8) begin errors++; $display("FAIL clean_total: got %0d expected 8", bus0.TOTAL_CNT); end
    checks++; if (bus0.FAIL_CNT !== 32'd0) begin errors++; $display("FAIL clean_fail: got %0d expected 0", bus0.FAIL_CNT); end
    checks++; if (bus0.ERR_VALID !== 1'b0) begin errors++; $display("FAIL clean_err_valid: got %b expected 0", bus0.ERR_VALID); end
  endtask

  task automatic test_mismatch_log();
    start_run();
    checks++; if (bus0.TOTAL_CNT !== 32'd0) begin errors++; $display("FAIL mlog_clear: got %0d expected 0", bus0.TOTAL_CNT); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) send_vec(32'h3F800000, 32'h3F800000, 32'h40000001, 32'h40000000, 1'b0);
      else        send_vec(32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, i == 4);
    end
    step();
    checks++; if (bus0.FAIL_CNT !== 32'd1 || bus0.TOTAL_CNT !== 32'd5) begin errors++;
      $display("FAIL mlog_counts: got fail %0d total %0d expected 1 5", bus0.FAIL_CNT, bus0.TOTAL_CNT); end
    checks++; if (bus0.ERR_VALID !== 1'b1) begin errors++; $display("FAIL mlog_valid: got %b expected 1", bus0.ERR_VALID); end
    checks++; if (bus0.ERR_O !== 32'h40000001) begin errors++; $display("FAIL mlog_err_o: got %h expected 40000001", bus0.ERR_O); end
    checks++; if (bus0.ERR_GOLDEN !== 32'h40000000) begin errors++; $display("FAIL mlog_err_g: got %h expected 40000000", bus0.ERR_GOLDEN); end
    checks++; if (bus0.ERR_A !== 32'h3F800000 || bus0.ERR_B !== 32'h3F800000) begin errors++;
      $display("FAIL mlog_err_ab: got %h %h expected 3f800000 3f800000", bus0.ERR_A, bus0.ERR_B); end
    err_pop = 1'b1;
    step();
    err_pop = 1'b0;
    checks++; if (bus0.ERR_VALID !== 1'b0 || bus0.ERR_O !== 32'd0 || bus0.ERR_A !== 32'd0) begin errors++;
      $display("FAIL mlog_pop: got valid %b o %h a %h expected 0 0 0", bus0.ERR_VALID, bus0.ERR_O, bus0.ERR_A); end
  endtask

  task automatic test_nan();
    start_run();
    send_vec(32'd0, 32'd0, 32'h7FC00000, 32'hFFC00001, 1'b0);
    send_vec(32'd0, 32'd0, 32'h7F800000, 32'h7F800000, 1'b0);
    send_vec(32'd0, 32'd0, 32'h80000000, 32'h00000000, 1'b1);
    step();
    checks++; if (bus0.FAIL_CNT !== 32'd1) begin errors++; $display("FAIL nan_relaxed: got %0d expected 1", bus0.FAIL_CNT); end
    checks++; if (bus1.FAIL_CNT !== 32'd2) begin errors++; $display("FAIL nan_strict: got %0d expected 2", bus1.FAIL_CNT); end
    checks++; if (bus0.ERR_O !== 32'h80000000) begin errors++; $display("FAIL nan_relaxed_log: got %h expected 80000000", bus0.ERR_O); end
    checks++; if (bus1.ERR_O !== 32'h7FC00000) begin errors++; $display("FAIL nan_strict_log: got %h expected 7fc00000", bus1.ERR_O); end
  endtask

  task automatic test_overflow();
    start_run();
    for (int i = 0; i < 20; i++) send_vec(i, 32'h100 + i, 32'h1000 + i, 32'h2000, i == 19);
    step();
    checks++; if (bus0.FAIL_CNT !== 32'd20 || bus0.TOTAL_CNT !== 32'd20) begin errors++;
      $display("FAIL ovf_counts: got fail %0d total %0d expected 20 20", bus0.FAIL_CNT, bus0.TOTAL_CNT); end
    checks++; if (bus0.LOG_OVF !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus0.LOG_OVF); end
    checks++; if (bus2.TOTAL_CNT !== 4'd15 || bus2.FAIL_CNT !== 4'd15) begin errors++;
      $display("FAIL sat_counts: got total %0d fail %0d expected 15 15", bus2.TOTAL_CNT, bus2.FAIL_CNT); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus0.ERR_VALID !== 1'b1 || bus0.ERR_A !== i || bus0.ERR_O !== 32'h1000 + i) begin errors++;
        $display("FAIL ovf_entry%0d: got valid %b a %h o %h", i, bus0.ERR_VALID, bus0.ERR_A, bus0.ERR_O); end
      err_pop = 1'b1;
      step();
      err_pop = 1'b0;
    end
    checks++; if (bus0.ERR_VALID !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", bus0.ERR_VALID); end
    checks++; if (bus0.LOG_OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus0.LOG_OVF); end
  endtask

  task automatic test_overflow_pop();
    int          n;
    logic [31:0] last_a;
    start_run();
    checks++; if (bus0.LOG_OVF !== 1'b0) begin errors++; $display("FAIL ovfpop_clear: got %b expected 0", bus0.LOG_OVF); end
    for (int i = 0; i < 17; i++) send_vec(i, 32'd0, 32'h1000 + i, 32'h2000, i == 16);
    err_pop = 1'b1;
    step();
    err_pop = 1'b0;
    checks++; if (bus0.LOG_OVF !== 1'b0) begin errors++; $display("FAIL ovfpop_flag: got %b expected 0", bus0.LOG_OVF); end
    checks++; if (bus0.ERR_A !== 32'd1) begin errors++; $display("FAIL ovfpop_head: got %h expected 1", bus0.ERR_A); end
    n = 0;
    last_a = 32'hFFFFFFFF;
    while (bus0.ERR_VALID === 1'b1 && n < 20) begin
      last_a = bus0.ERR_A;
      err_pop = 1'b1;
      step();
      err_pop = 1'b0;
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL ovfpop_entries: got %0d expected 16", n); end
    checks++; if (last_a !== 32'd16) begin errors++; $display("FAIL ovfpop_tail: got %h expected 10", last_a); end
  endtask

  task automatic test_start_in_run();
    start_run();
    send_vec(32'd0, 32'd0, 32'd5, 32'd5, 1'b0);
    send_vec(32'd0, 32'd0, 32'd5, 32'd5, 1'b0);
    start = 1'b1;
    send_vec(32'd0, 32'd0, 32'd6, 32'd5, 1'b0);
    start = 1'b0;
    send_vec(32'd0, 32'd0, 32'd5, 32'd5, 1'b1);
    step();
    checks++; if (bus0.TOTAL_CNT !== 32'd4 || bus0.FAIL_CNT !== 32'd1) begin errors++;
      $display("FAIL start_in_run: got total %0d fail %0d expected 4 1", bus0.TOTAL_CNT, bus0.FAIL_CNT); end
    checks++; if (bus0.DONE !== 1'b1) begin errors++; $display("FAIL start_in_run_done: got %b expected 1", bus0.DONE); end
  endtask

  task automatic test_reset_midrun();
    start_run();
    for (int i = 0; i < 3; i++) send_vec(32'd7, 32'd7, 32'd1, 32'd2, 1'b0);
    nrst = 1'b0;
    #2;
    checks++; if (bus0.BUSY !== 1'b0 || bus0.DONE !== 1'b0) begin errors++;
      $display("FAIL rst_mid_state: got busy %b done %b expected 0 0", bus0.BUSY, bus0.DONE); end
    checks++; if (bus0.TOTAL_CNT !== 32'd0 || bus0.FAIL_CNT !== 32'd0) begin errors++;
      $display("FAIL rst_mid_counts: got %0d %0d expected 0 0", bus0.TOTAL_CNT, bus0.FAIL_CNT); end
    checks++; if (bus0.ERR_VALID !== 1'b0 || bus0.ERR_A !== 32'd0) begin errors++;
      $display("FAIL rst_mid_log: got valid %b a %h expected 0 0", bus0.ERR_VALID, bus0.ERR_A); end
    nrst = 1'b1;
    step();
    start_run();
    send_vec(32'd0, 32'd0, 32'd1, 32'd2, 1'b0);
    send_vec(32'd0, 32'd0, 32'd3, 32'd3, 1'b1);
    step();
    checks++; if (bus0.TOTAL_CNT !== 32'd2 || bus0.FAIL_CNT !== 32'd1 || bus0.DONE !== 1'b1) begin errors++;
      $display("FAIL rst_restart: got total %0d fail %0d done %b expected 2 1 1", bus0.TOTAL_CNT, bus0.FAIL_CNT, bus0.DONE); end
  endtask

  initial begin
    checks = 0; errors = 0;
    start = 1'b0; en = 1'b0; last = 1'b0; err_pop = 1'b0;
    a = 32'd0; b = 32'd0; o = 32'd0; g = 32'd0;
    test_reset();
    test_en_idle();
    test_clean_run();
    test_mismatch_log();
    test_nan();
    test_overflow();
    test_overflow_pop();
    test_start_in_run();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
